// File: rtl/ram_explorer_if.sv
// Switch/key inputs and display/LED outputs of the RAM explorer.
// The DUT takes the slave side. The board or bench drives the master side.
interface ram_explorer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] data_in;
    logic [1:0]        mode;
    logic              wr_btn;
    logic              start_btn;
    logic [DATA_W-1:0] q;
    logic [ADDR_W-1:0] cur_addr;
    logic              busy;
    logic              done;

    modport master (
        output addr_in, data_in, mode, wr_btn, start_btn,
        input  q, cur_addr, busy, done
    );

    modport slave (
        input  addr_in, data_in, mode, wr_btn, start_btn,
        output q, cur_addr, busy, done
    );
endinterface

// File: rtl/ram_explorer.sv
// On-chip RAM with a control FSM for manual write/read, patterned fill, clear and a timed scan.
// Buttons are synchronised and edge-detected so that each press acts exactly once.
module ram_explorer #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 5,
    parameter int SCAN_DWELL = 50_000_000
) (
    input  logic            clock,
    input  logic            resetn,
    ram_explorer_if.slave   bus
);
    localparam int                DW_W       = (SCAN_DWELL > 1) ? $clog2(SCAN_DWELL) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;
    localparam logic [DW_W-1:0]   DWELL_LAST = DW_W'(SCAN_DWELL - 1);
    localparam int                DEPTH      = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, FILL, SCAN, CLEAR} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DW_W-1:0]   dwell_q, dwell_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [DATA_W-1:0] q_q;

    logic [2:0]        wr_sync_q, start_sync_q;
    logic              wr_p_q, start_p_q;

    logic              we;
    logic [ADDR_W-1:0] waddr, raddr;
    logic [DATA_W-1:0] wdata;

    logic [DATA_W-1:0] mem [DEPTH];

    // Two flops to resynchronise, a third for the rising-edge compare.
    // NOTE: sequential state uses <= so that every flop samples pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_sync_q    <= '0;
            start_sync_q <= '0;
            wr_p_q       <= 1'b0;
            start_p_q    <= 1'b0;
        end else begin
            wr_sync_q    <= {wr_sync_q[1:0], bus.wr_btn};
            start_sync_q <= {start_sync_q[1:0], bus.start_btn};
            wr_p_q       <= wr_sync_q[1] & ~wr_sync_q[2];
            start_p_q    <= start_sync_q[1] & ~start_sync_q[2];
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            dwell_q    <= '0;
            seed_q     <= '0;
            done_q     <= 1'b0;
            cur_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            dwell_q    <= dwell_d;
            seed_q     <= seed_d;
            done_q     <= done_d;
            cur_addr_q <= cur_addr_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dwell_d = dwell_q;
        seed_d  = seed_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_p_q) begin
                    idx_d   = '0;
                    dwell_d = '0;
                    seed_d  = bus.data_in;
                    unique case (bus.mode)
                        2'b01:   state_d = FILL;
                        2'b10:   state_d = SCAN;
                        2'b11:   state_d = CLEAR;
                        default: state_d = IDLE;
                    endcase
                end
            end
            FILL, CLEAR: begin
                if (start_p_q) begin
                    state_d = IDLE;
                end else if (idx_q == LAST_ADDR) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            SCAN: begin
                if (start_p_q) begin
                    state_d = IDLE;
                end else if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    if (idx_q == LAST_ADDR) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // An abort pulse suppresses the write of the word that would have been written in that cycle.
    always_comb begin
        we         = 1'b0;
        waddr      = idx_q;
        wdata      = seed_q + DATA_W'(idx_q);
        raddr      = idx_q;
        cur_addr_d = idx_q;
        unique case (state_q)
            IDLE: begin
                raddr      = bus.addr_in;
                cur_addr_d = bus.addr_in;
                waddr      = bus.addr_in;
                wdata      = bus.data_in;
                we         = wr_p_q && !start_p_q && (bus.mode == 2'b00);
            end
            FILL:    we = !start_p_q;
            CLEAR: begin
                we    = !start_p_q;
                wdata = '0;
            end
            default: we = 1'b0;
        endcase
    end

    // NOTE: the RAM array has no reset, so it maps onto block RAM and keeps contents across resetn.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            q_q <= '0;
        end else begin
            q_q <= mem[raddr];
        end
    end

    assign bus.q        = q_q;
    assign bus.cur_addr = cur_addr_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;

endmodule

// File: tb/tb_ram_explorer.sv
// Directed bench for ram_explorer: clear, manual write, fill, scan, aborted fill, reset mid-scan.
// A model memory and a queue of expected reads hold the reference values.
module tb_ram_explorer;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;
    localparam int DWELL  = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    ram_explorer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    ram_explorer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SCAN_DWELL(DWELL)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    exp_t              sb[$];
    logic [DATA_W-1:0] model_mem [DEPTH];
    int                total = 0;
    int                bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge: drive address, expect data after the next rising edge.
    task automatic read_check(input int a);
        exp_t e;
        e.addr = ADDR_W'(a);
        e.data = model_mem[a];
        bus.addr_in = e.addr;
        sb.push_back(e);
        @(negedge clock);
        e = sb.pop_front();
        check("rd_q", 32'(bus.q), 32'(e.data));
        check("rd_addr", 32'(bus.cur_addr), 32'(e.addr));
    endtask

    task automatic sweep();
        for (int i = 0; i < DEPTH; i++) read_check(i);
    endtask

    // start_btn is already high; count busy/done cycles over a fixed window.
    task automatic run_op(input int cycles, input int drop_at, output int busy_cnt, output int done_cnt);
        busy_cnt = 0;
        done_cnt = 0;
        for (int c = 1; c <= cycles; c++) begin
            @(negedge clock);
            if (c == drop_at) begin
                bus.start_btn = 1'b0;
                bus.data_in   = ~bus.data_in;
            end
            busy_cnt += int'(bus.busy);
            done_cnt += int'(bus.done);
        end
    endtask

    initial begin
        int   bc, dc;
        exp_t cur;

        bus.addr_in   = '0;
        bus.data_in   = '0;
        bus.mode      = 2'b00;
        bus.wr_btn    = 1'b0;
        bus.start_btn = 1'b0;
        cur           = '0;

        repeat (2) @(negedge clock);
        check("rst_q", 32'(bus.q), 0);
        check("rst_addr", 32'(bus.cur_addr), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        resetn = 1'b1;
        @(negedge clock);

        // CLEAR
        bus.mode      = 2'b11;
        bus.start_btn = 1'b1;
        run_op(45, 5, bc, dc);
        check("clr_busy_cycles", 32'(bc), 32);
        check("clr_done_pulses", 32'(dc), 1);
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        sweep();

        // MANUAL write with a long press; data changes mid-press must not be written
        bus.mode    = 2'b00;
        bus.addr_in = 5'h0A;
        bus.data_in = 8'h5C;
        bus.wr_btn  = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            if (c == 4) check("wr_old_q", 32'(bus.q), 32'h00);
            if (c == 5) check("wr_new_q", 32'(bus.q), 32'h5C);
            if (c == 7) bus.data_in = 8'h33;
        end
        bus.wr_btn = 1'b0;
        repeat (3) @(negedge clock);
        model_mem[10] = 8'h5C;
        read_check(10);
        read_check(11);

        // FILL with seed 0xF0; seed change after start must be ignored
        bus.mode      = 2'b01;
        bus.data_in   = 8'hF0;
        bus.start_btn = 1'b1;
        run_op(45, 5, bc, dc);
        check("fill_busy_cycles", 32'(bc), 32);
        check("fill_done_pulses", 32'(dc), 1);
        for (int i = 0; i < DEPTH; i++) model_mem[i] = DATA_W'(8'hF0 + i);
        sweep();

        // SCAN: each address shown for DWELL cycles
        bus.mode      = 2'b10;
        bus.start_btn = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            exp_t e;
            e.addr = ADDR_W'(i);
            e.data = model_mem[i];
            sb.push_back(e);
        end
        bc = 0;
        dc = 0;
        for (int c = 1; c <= 140; c++) begin
            @(negedge clock);
            if (c == 3) bus.start_btn = 1'b0;
            bc += int'(bus.busy);
            dc += int'(bus.done);
            if (c >= 5 && c <= 4 + DEPTH * DWELL) begin
                if ((c - 5) % DWELL == 0) cur = sb.pop_front();
                if ((c - 5) % DWELL == 0 || (c - 5) % DWELL == DWELL - 1) begin
                    check("scan_addr", 32'(bus.cur_addr), 32'(cur.addr));
                    check("scan_q", 32'(bus.q), 32'(cur.data));
                end
            end
        end
        check("scan_busy_cycles", 32'(bc), DEPTH * DWELL);
        check("scan_done_pulses", 32'(dc), 1);
        check("scan_sb_empty", 32'(sb.size()), 0);
        check("scan_busy_after", 32'(bus.busy), 0);

        // FILL aborted at idx 8; write press and mode change while busy
        bus.mode      = 2'b01;
        bus.data_in   = 8'h40;
        bus.start_btn = 1'b1;
        bc = 0;
        dc = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clock);
            if (c == 3) bus.start_btn = 1'b0;
            if (c == 5) begin
                bus.wr_btn  = 1'b1;
                bus.mode    = 2'b00;
                bus.addr_in = 5'h14;
                bus.data_in = 8'h99;
            end
            if (c == 7)  bus.wr_btn = 1'b0;
            if (c == 9)  bus.start_btn = 1'b1;
            if (c == 12) bus.start_btn = 1'b0;
            bc += int'(bus.busy);
            dc += int'(bus.done);
        end
        check("abort_busy_cycles", 32'(bc), 9);
        check("abort_done_pulses", 32'(dc), 0);
        for (int i = 0; i < 8; i++) model_mem[i] = DATA_W'(8'h40 + i);
        sweep();

        // Reset in the middle of a SCAN
        bus.mode      = 2'b10;
        bus.start_btn = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (c == 3) bus.start_btn = 1'b0;
        end
        check("pre_rst_busy", 32'(bus.busy), 1);
        check("pre_rst_addr", 32'(bus.cur_addr), 3);
        #1 resetn = 1'b0;
        #1;
        check("async_rst_q", 32'(bus.q), 0);
        check("async_rst_addr", 32'(bus.cur_addr), 0);
        check("async_rst_busy", 32'(bus.busy), 0);
        check("async_rst_done", 32'(bus.done), 0);
        repeat (2) @(negedge clock);
        resetn   = 1'b1;
        bus.mode = 2'b00;
        @(negedge clock);
        read_check(3);
        read_check(16);
        check("post_rst_busy", 32'(bus.busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
